commit_trace_serializer: RTL

- Takes the 2-wide retire (commit) stream of the core and turns it into a 1-wide, program-ordered trace stream.
- The trace stream has a valid/ready handshake, so a trace consumer (co-sim checker, trace encoder, log port) can apply backpressure.
- Commit cannot be stalled. A circular buffer absorbs bursts. Any commit group that does not fit is dropped as a whole and flagged.
- Sits between the core commit debug signals and the harness/trace sink.

---
 rtl/commit_trace_serializer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/commit_trace_serializer.sv
// commit_trace_serializer
//
// Turns the 2-wide retire stream of the core into a 1-wide, program-ordered
// trace stream with a valid/ready handshake. Retirement cannot be stalled, so
// a circular buffer absorbs bursts. A commit group that does not fit in the
// free space is dropped as a whole, and the sticky overflow flag is raised.
// Every accepted instruction is stamped with a dense 64-bit retire sequence
// number.
//
// Optional feature (macro COMMIT_TRACE_DROP_CNT_EN): adds a 32-bit saturating
// drop_cnt output. It counts every instruction lost to a rejected group.
//
// Ports:
//   clock, reset                  core clock, synchronous active-high reset
//   hartid                        hart id, forwarded live on trace_hartid
//   commit_arch_valids_0/1        slot 0 / slot 1 retire this cycle
//   commit_uops_{0,1}_ldst        destination logical register
//   commit_uops_{0,1}_dst_rtype   destination register type
//   commit_uops_{0,1}_debug_pc    instruction PC
//   commit_uops_{0,1}_debug_wdata writeback data
//   commit_uops_{0,1}_debug_inst  instruction bits
//   trace_valid / trace_ready     head-beat handshake
//   trace_hartid, trace_pc, trace_inst, trace_wdata, trace_ldst,
//   trace_rtype, trace_seq        fields of the head beat
//   level                         current buffer occupancy
//   drop_cnt                      (optional) instructions dropped, saturating
//   overflow                      sticky: at least one group was dropped

module commit_trace_serializer #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 40,
  parameter int XLEN   = 64,
  parameter int LREG_W = 5
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [7:0]               hartid,
  input  logic                     commit_arch_valids_0,
  input  logic                     commit_arch_valids_1,
  input  logic [LREG_W-1:0]        commit_uops_0_ldst,
  input  logic [LREG_W-1:0]        commit_uops_1_ldst,
  input  logic [2:0]               commit_uops_0_dst_rtype,
  input  logic [2:0]               commit_uops_1_dst_rtype,
  input  logic [ADDR_W-1:0]        commit_uops_0_debug_pc,
  input  logic [ADDR_W-1:0]        commit_uops_1_debug_pc,
  input  logic [XLEN-1:0]          commit_uops_0_debug_wdata,
  input  logic [XLEN-1:0]          commit_uops_1_debug_wdata,
  input  logic [31:0]              commit_uops_0_debug_inst,
  input  logic [31:0]              commit_uops_1_debug_inst,
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output logic [7:0]               trace_hartid,
  output logic [ADDR_W-1:0]        trace_pc,
  output logic [31:0]              trace_inst,
  output logic [XLEN-1:0]          trace_wdata,
  output logic [LREG_W-1:0]        trace_ldst,
  output logic [2:0]               trace_rtype,
  output logic [63:0]              trace_seq,
  output logic [$clog2(DEPTH):0]   level,
`ifdef COMMIT_TRACE_DROP_CNT_EN
  output logic [31:0]              drop_cnt,
`endif
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [31:0]       inst;
    logic [XLEN-1:0]   wdata;
    logic [LREG_W-1:0] ldst;
    logic [2:0]        rtype;
    logic [63:0]       seq;
  } entry_t;

  entry_t            mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [63:0]       seq_ctr;
  logic              overflow_q;

  logic [1:0]        push_n;
  logic [CNT_W-1:0]  free_slots;
  logic              accept;
  logic              reject;
  logic              pop;
  logic [PTR_W-1:0]  slot1_addr;
  logic [63:0]       slot1_seq;
  entry_t            slot0_entry;
  entry_t            slot1_entry;
  entry_t            head;

  // Admission is judged on the occupancy at the start of the cycle only, so a
  // pop happening in the same cycle never makes room for this cycle's group.
  // Slot 1 is compacted down onto slot 0's position when slot 0 is idle.
  always_comb begin
    push_n     = {1'b0, commit_arch_valids_0} + {1'b0, commit_arch_valids_1};
    free_slots = CNT_W'(DEPTH) - count;
    accept     = (push_n != 2'd0) && (free_slots >= {{(CNT_W-2){1'b0}}, push_n});
    reject     = (push_n != 2'd0) && !accept;
    pop        = (count != '0) && trace_ready;
    slot1_addr = commit_arch_valids_0 ? (wr_ptr + PTR_W'(1)) : wr_ptr;
    slot1_seq  = commit_arch_valids_0 ? (seq_ctr + 64'd1) : seq_ctr;

    slot0_entry.pc    = commit_uops_0_debug_pc;
    slot0_entry.inst  = commit_uops_0_debug_inst;
    slot0_entry.wdata = commit_uops_0_debug_wdata;
    slot0_entry.ldst  = commit_uops_0_ldst;
    slot0_entry.rtype = commit_uops_0_dst_rtype;
    slot0_entry.seq   = seq_ctr;

    slot1_entry.pc    = commit_uops_1_debug_pc;
    slot1_entry.inst  = commit_uops_1_debug_inst;
    slot1_entry.wdata = commit_uops_1_debug_wdata;
    slot1_entry.ldst  = commit_uops_1_ldst;
    slot1_entry.rtype = commit_uops_1_dst_rtype;
    slot1_entry.seq   = slot1_seq;
  end

  // Storage carries no reset; occupancy alone decides which entries are live.
  // Commits seen while reset is asserted are not written.
  always_ff @(posedge clock) begin
    if (!reset && accept) begin
      if (commit_arch_valids_0) mem[wr_ptr] <= slot0_entry;
      if (commit_arch_valids_1) mem[slot1_addr] <= slot1_entry;
    end
  end

  // Pointer, occupancy, sequence and overflow bookkeeping. Pointers wrap
  // naturally because their width is log2(DEPTH).
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      seq_ctr    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr  <= wr_ptr + PTR_W'(push_n);
        seq_ctr <= seq_ctr + 64'(push_n);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (reject) overflow_q <= 1'b1;
      count <= count + (accept ? {{(CNT_W-2){1'b0}}, push_n} : '0)
                     - {{(CNT_W-1){1'b0}}, pop};
    end
  end

`ifdef COMMIT_TRACE_DROP_CNT_EN
  logic [31:0] drop_cnt_q;
  logic [32:0] drop_sum;

  assign drop_sum = {1'b0, drop_cnt_q} + 33'(push_n);

  // Counts instructions rather than groups, and sticks at all-ones.
  always_ff @(posedge clock) begin
    if (reset) begin
      drop_cnt_q <= '0;
    end else if (reject) begin
      drop_cnt_q <= drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

  assign head         = mem[rd_ptr];
  assign trace_valid  = (count != '0);
  assign trace_hartid = hartid;
  assign trace_pc     = head.pc;
  assign trace_inst   = head.inst;
  assign trace_wdata  = head.wdata;
  assign trace_ldst   = head.ldst;
  assign trace_rtype  = head.rtype;
  assign trace_seq    = head.seq;
  assign level        = count;
  assign overflow     = overflow_q;

endmodule
